// File: rtl/alu_pkg.sv
// Shared opcode encodings and controller state type for the multicycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND    = 4'd0;
    localparam logic [3:0] OP_OR     = 4'd1;
    localparam logic [3:0] OP_NEGATE = 4'd2;
    localparam logic [3:0] OP_NOT    = 4'd3;
    localparam logic [3:0] OP_ADD    = 4'd4;
    localparam logic [3:0] OP_SUB    = 4'd5;
    localparam logic [3:0] OP_MUL    = 4'd6;
    localparam logic [3:0] OP_DIV    = 4'd7;
    localparam logic [3:0] OP_SHR    = 4'd8;
    localparam logic [3:0] OP_SHRA   = 4'd9;
    localparam logic [3:0] OP_SHL    = 4'd10;
    localparam logic [3:0] OP_ROR    = 4'd11;
    localparam logic [3:0] OP_ROL    = 4'd12;

    // EXEC keeps its encoding slot; single-cycle ops resolve on the accepting
    // edge and go straight to DONE so that busy never rises for them.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXEC    = 3'd1,
        MUL_IT  = 3'd2,
        DIV_IT  = 3'd3,
        DIV_FIX = 3'd4,
        DONE    = 3'd5
    } alu_state_t;

    function automatic logic is_illegal_op(input logic [3:0] opcode);
        return opcode > OP_ROL;
    endfunction

endpackage

// File: rtl/nr_divider_seq.sv
// Iterative signed non-restoring divider: one quotient bit per step, then a
// combinational remainder correction and sign fixup read out in DIV_FIX.
module nr_divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    logic [WIDTH+1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH+1:0] dsr_ext, shifted, rem_fix;
    logic [WIDTH-1:0] quo_mag, rem_mag;

    always_comb begin
        a_mag   = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
        b_mag   = divisor_i[WIDTH-1]  ? -divisor_i  : divisor_i;
        dsr_ext = {2'b00, dsr_q};
        // Quotient register doubles as the dividend shifter feeding the remainder.
        shifted = {rem_q[WIDTH:0], quo_q[WIDTH-1]};

        rem_d  = rem_q;
        quo_d  = quo_q;
        dsr_d  = dsr_q;
        dvd_d  = dvd_q;
        negq_d = negq_q;
        negr_d = negr_q;
        dz_d   = dz_q;

        if (load_i) begin
            rem_d  = '0;
            quo_d  = a_mag;
            dsr_d  = b_mag;
            dvd_d  = dividend_i;
            negq_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
            negr_d = dividend_i[WIDTH-1];
            dz_d   = (divisor_i == '0);
        end else if (step_i) begin
            rem_d = rem_q[WIDTH+1] ? shifted + dsr_ext : shifted - dsr_ext;
            quo_d = {quo_q[WIDTH-2:0], ~rem_d[WIDTH+1]};
        end
    end

    always_comb begin
        rem_fix = rem_q[WIDTH+1] ? rem_q + dsr_ext : rem_q;
        quo_mag = quo_q;
        rem_mag = rem_fix[WIDTH-1:0];
        if (dz_q) begin
            quotient_o  = '1;
            remainder_o = dvd_q;
        end else begin
            quotient_o  = negq_q ? -quo_mag : quo_mag;
            remainder_o = negr_q ? -rem_mag : rem_mag;
        end
        div_by_zero_o = dz_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            dvd_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
            dvd_q  <= dvd_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            dz_q   <= dz_d;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith/shift ops, iterative Booth multiply
// and a non-restoring divide, with a one-cycle done pulse and held result.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] C,
    output logic               div_by_zero,
    output logic               illegal_op
);

    localparam int CNTW = $clog2(WIDTH) + 1;

    alu_state_t         state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] c_q, c_d;
    logic               dz_q, dz_d;
    logic               ill_q, ill_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic               qm1_q, qm1_d;

    logic               accept;
    logic               div_load, div_step;
    logic [WIDTH-1:0]   div_quo, div_rem;
    logic               div_dz;

    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] rot_r, rot_l;
    logic [WIDTH-1:0]   simple_lo;

    logic [WIDTH:0]     m_ext, booth_sum, booth_acc;
    logic [WIDTH-1:0]   booth_mq;

    always_comb begin
        amt   = B[SHW-1:0];
        rot_r = {A, A} >> amt;
        rot_l = {A, A} << amt;
        case (op)
            OP_AND:    simple_lo = A & B;
            OP_OR:     simple_lo = A | B;
            OP_NEGATE: simple_lo = -A;
            OP_NOT:    simple_lo = ~A;
            OP_ADD:    simple_lo = A + B;
            OP_SUB:    simple_lo = A - B;
            OP_SHR:    simple_lo = A >> amt;
            OP_SHRA:   simple_lo = $signed(A) >>> amt;
            OP_SHL:    simple_lo = A << amt;
            OP_ROR:    simple_lo = rot_r[WIDTH-1:0];
            OP_ROL:    simple_lo = rot_l[2*WIDTH-1:WIDTH];
            default:   simple_lo = '0;
        endcase
    end

    // Radix-2 Booth step on {acc, multiplier, q-1}; acc carries one guard bit.
    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        case ({mq_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase
        booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_mq  = {booth_sum[0], mq_q[WIDTH-1:1]};
    end

    always_comb begin
        accept   = start && ((state_q == IDLE) || (state_q == DONE));
        div_load = accept && (op == OP_DIV);
        div_step = (state_q == DIV_IT);

        state_d = state_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        dz_d    = dz_q;
        ill_d   = ill_q;
        m_d     = m_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (op == OP_MUL) begin
                        m_d     = A;
                        acc_d   = '0;
                        mq_d    = B;
                        qm1_d   = 1'b0;
                        cnt_d   = CNTW'(WIDTH - 1);
                        state_d = MUL_IT;
                    end else if (op == OP_DIV) begin
                        cnt_d   = CNTW'(WIDTH - 1);
                        state_d = DIV_IT;
                    end else if (is_illegal_op(op)) begin
                        c_d     = '0;
                        dz_d    = 1'b0;
                        ill_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        c_d     = {{WIDTH{1'b0}}, simple_lo};
                        dz_d    = 1'b0;
                        ill_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            MUL_IT: begin
                acc_d = booth_acc;
                mq_d  = booth_mq;
                qm1_d = mq_q[0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    c_d     = {booth_acc[WIDTH-1:0], booth_mq};
                    dz_d    = 1'b0;
                    ill_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DIV_IT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                c_d     = {div_rem, div_quo};
                dz_d    = div_dz;
                ill_d   = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            c_q     <= '0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
            m_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            dz_q    <= dz_d;
            ill_q   <= ill_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
        end
    end

    nr_divider_seq #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk_i        (clock),
        .rst_i        (clear),
        .load_i       (div_load),
        .step_i       (div_step),
        .dividend_i   (A),
        .divisor_i    (B),
        .quotient_o   (div_quo),
        .remainder_o  (div_rem),
        .div_by_zero_o(div_dz)
    );

    assign busy        = (state_q == MUL_IT) || (state_q == DIV_IT) || (state_q == DIV_FIX);
    assign done        = (state_q == DONE);
    assign C           = c_q;
    assign div_by_zero = dz_q;
    assign illegal_op  = ill_q;

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width (even, >=8).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount field width.
REQ-003 SHALL have one clock, `clock`; reset `clear` is synchronous and active-high.
REQ-004 SHALL have port list:
- clock  in  1  rising-edge clock
- clear  in  1  synchronous active-high reset
- start  in  1  request; samples op/A/B
- op  in  4  opcode
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- busy  out  1  operation in progress
- done  out  1  one-cycle result-valid pulse
- C  out  2*WIDTH  result, {HI, LO}
- div_by_zero  out  1  valid with done
- illegal_op  out  1  valid with done

Function
REQ-005 SHALL use opcodes AND=0, OR=1, NEGATE=2, NOT=3, ADD=4, SUB=5, MUL=6, DIV=7, SHR=8, SHRA=9, SHL=10, ROR=11, ROL=12; 13-15 are illegal.
REQ-006 SHALL accept start only in IDLE or DONE; start while busy is ignored.
REQ-007 SHALL capture op, A and B on the accepting edge; later input changes do not affect the result.
REQ-008 SHALL use states IDLE, EXEC, MUL_IT, DIV_IT, DIV_FIX and DONE; DONE lasts exactly one cycle, then goes to IDLE or, if start is set, to the next op.
REQ-009 SHALL assert done N cycles after the accepting edge: simple/illegal N=1, MUL N=WIDTH+1, DIV N=WIDTH+2.
REQ-010 SHALL hold busy high from the cycle after acceptance until done rises; busy and done are never high together.
REQ-011 SHALL hold C, div_by_zero and illegal_op stable from done until the next done.
REQ-012 SHALL set HI=0 for non-MUL/DIV ops; NEGATE=-A, NOT=~A, ADD/SUB modulo 2^WIDTH.
REQ-013 SHALL use B[SHW-1:0] as the shift/rotate amount; upper B bits are ignored; SHRA sign-fills.
REQ-014 SHALL compute MUL as a signed radix-2 Booth product over WIDTH iterations, giving a full 2*WIDTH result.
REQ-015 SHALL compute DIV as signed non-restoring division: LO=quotient (truncated toward zero), HI=remainder (sign of dividend); DIV_FIX does the correction and sign fixup.
REQ-016 SHALL, on DIV with B=0, give LO=all-ones and HI=A, set div_by_zero, and still take N=WIDTH+2.
REQ-017 SHALL, on DIV of most-negative/-1, give LO=most-negative and HI=0 with no flag.
REQ-018 SHALL, on an illegal op, give C=0 and set illegal_op.

Reset
REQ-019 SHALL, while clear is high, drive state IDLE, busy=0, done=0, C=0, div_by_zero=0 and illegal_op=0.
REQ-020 SHALL let clear abort an in-flight MUL/DIV with no done pulse; clear wins over start in the same cycle.

Structure
REQ-021 SHALL keep opcode constants and the state enum in shared package alu_pkg.
REQ-022 SHALL implement the iterative divider (DIV_IT/DIV_FIX datapath) as sub-module nr_divider_seq; Booth MUL stays inline.

Verification
REQ-023 SHALL cover: ADD A=32'h7FFFFFFF, B=1 -> done at +1, C=64'h0000_0000_8000_0000, busy never high.
REQ-024 SHALL cover: MUL A=-3, B=7 -> done at +33, C=64'hFFFF_FFFF_FFFF_FFEB; operands changed after start have no effect.
REQ-025 SHALL cover: DIV A=-7, B=2 -> done at +34, LO=-3, HI=-1; then DIV B=0 -> LO=all-ones, HI=A, div_by_zero=1.
REQ-026 SHALL cover: SHRA A=32'h80000000, B=32'h21 (amount 1) -> LO=32'hC0000000; ROL A=32'h80000001, B=4 -> LO=32'h00000018.
REQ-027 SHALL cover: start held during MUL -> ignored until done; clear at +10 of DIV -> no done, all outputs 0 next cycle.
REQ-028 SHALL cover: op=4'hE -> done at +1, C=0, illegal_op=1; back-to-back start in the DONE cycle is accepted.
